display_arbiter: RTL and testbench
==================================

# display_arbiter

Shares the single 4-digit 7-segment driver between two display clients (e.g. scrolling banner and status counter). Grants the display to one client at a time with round-robin arbitration, a minimum ownership time counted in `tick_banner` ticks, and an optional blank guard frame between owners. Scans the owner's 16-bit word onto the driver's `value`/`off_display` inputs in step with `tick_display`. Sits between the clients and `driver7seg`, beside `clk_div`.

## Interface
- `HOLD_TICKS`, 4: minimum number of `tick_banner` ticks an owner keeps the display before it can be preempted; range 0..255.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tick_display` in 1: one-cycle digit-scan strobe from `clk_div`.
- `tick_banner` in 1: one-cycle slow strobe from `clk_div`.
- `req` in 2: request per client; level, held while the client wants the display.
- `data0` in 16: client 0 word; nibble k is shown on digit k.
- `data1` in 16: client 1 word.
- `blank0` in 4: client 0 per-digit blank mask; 1 turns the digit off.
- `blank1` in 4: client 1 per-digit blank mask.
- `gnt` out 2: one-hot grant, or 0.
- `value` out 4: nibble to `driver7seg.value`.
- `off_display` out 1: to `driver7seg.off_display`.
- `digit` out 2: current scan position.

## Operation
- Reset values: `gnt`=0, `value`=0, `off_display`=1, `digit`=0, state IDLE, hold counter 0, last-owner pointer = client 1, so client 0 wins the first tie.
- Scan:
  - `digit` increments modulo 4 on every `tick_display`, in all states; 3 wraps to 0.
  - On the same edge, `value` is loaded with the owner's nibble `[4*(digit+1) +: 4]` (next digit index).
  - On the same edge, `off_display` is loaded with 1 if there is no owner or the owner's blank bit for that digit is set; otherwise 0.
- States:
  - **IDLE**: `gnt`=0. If `req` is nonzero, go to OWN. Grant the single requester; on a tie, grant the client that is not the last owner. Load the hold counter with `HOLD_TICKS`.
  - **OWN**:
    - `gnt` is one-hot. Each `tick_banner` decrements the hold counter, saturating at 0.
    - If the owner drops `req`, go to GUARD regardless of the hold count.
    - If the hold count is 0 and the other client requests, go to GUARD (preemption).
    - Otherwise stay; a lone owner keeps the display indefinitely.
  - **GUARD**: `gnt`=0, `off_display` is forced to 1, and `value` holds its last value. Count 4 `tick_display` strobes (one blank frame), then go to IDLE.
  - On leaving OWN, update the last-owner pointer.
- Simultaneous events:
  - A `req` drop and `tick_banner` in the same cycle: the drop wins (GUARD).
  - A hold count reaching 0 and other-client `req` in the same cycle: preemption is evaluated against the pre-decrement count, so it takes effect the next cycle.
- Data and blank inputs are sampled live on every scan update. Clients change them freely while granted.
- Reset asserted mid-operation: all state returns to reset values immediately and asynchronously. `off_display` goes to 1 without waiting for a clock.

## Timing
- Grant latency: `req` sampled high in IDLE gives `gnt` high on the next edge (1 cycle).
- Release: the owner's `req` sampled low gives `gnt`=0 on the next edge.
- Display output latency: `value`/`off_display` change 1 cycle after `tick_display` is sampled high, together with `digit`.
- The first owned digit is displayed at the first `tick_display` after `gnt` rises.
- GUARD length: exactly 4 `tick_display` strobes; the exit edge is the one sampling the 4th strobe.
- `HOLD_TICKS`=0: the owner is preemptible from its first OWN cycle.

## Configuration
- `DISPLAY_ARB_GUARD_EN` defined: the GUARD state exists as described.
- `DISPLAY_ARB_GUARD_EN` undefined:
  - OWN exits directly to IDLE, so there is 1 cycle with `gnt`=0 between owners.
  - There is no forced blank frame.
  - Scan and arbitration are otherwise identical.

## Test plan
- Reset with `req`=2'b01: `gnt`=0 and `off_display`=1 during reset; `gnt`=2'b01 one cycle after release; with `data0`=16'h3210 and `blank0`=0, successive scans show `value` 0,1,2,3 on `digit` 0,1,2,3.
- Tie: `req`=2'b11 from reset, `HOLD_TICKS`=2: client 0 is granted first; after 2 `tick_banner` the grant goes to client 1 (via 4-strobe guard), then back to client 0 after 2 more ticks.
- Blank mask: owner 0 with `blank0`=4'b1010: `off_display`=1 on digits 1 and 3 and 0 on digits 0 and 2.
- Early release: owner 0 drops `req` with the hold counter at 3: `gnt`=0 on the next edge; client 1 is granted after the guard frame.
- `req` drop coinciding with `tick_banner`: GUARD is entered and the hold counter value is ignored; `rst` pulsed mid-GUARD sets `off_display`=1, `digit`=0 and IDLE asynchronously.
- Rebuild without `DISPLAY_ARB_GUARD_EN`: preemption shows exactly one `gnt`=0 cycle between 2'b01 and 2'b10.

Source files
------------

// File: rtl/display_arbiter_if.sv
// -----------------------------------------------------------------------------
// display_arbiter_if
//
// Purpose : bundles the scan strobes, the two client request/data/blank
//           inputs and the display-driver side outputs of display_arbiter.
//
// Signals : tick_display  scan strobe from clk_div
//           tick_banner   slow strobe from clk_div (hold-time unit)
//           req[1:0]      per-client level request
//           data0/data1   client words, nibble k shown on digit k
//           blank0/blank1 per-client per-digit blank masks (1 = digit off)
//           gnt[1:0]      one-hot grant or 0
//           value[3:0]    nibble to driver7seg.value
//           off_display   to driver7seg.off_display
//           digit[1:0]    current scan position
//
// Modports: master drives strobes and client inputs (clients + clk_div side),
//           slave is the arbiter itself.
// -----------------------------------------------------------------------------
interface display_arbiter_if;
    logic        tick_display;
    logic        tick_banner;
    logic [1:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [3:0]  blank0;
    logic [3:0]  blank1;
    logic [1:0]  gnt;
    logic [3:0]  value;
    logic        off_display;
    logic [1:0]  digit;

    modport master (
        output tick_display, tick_banner, req, data0, data1, blank0, blank1,
        input  gnt, value, off_display, digit
    );

    modport slave (
        input  tick_display, tick_banner, req, data0, data1, blank0, blank1,
        output gnt, value, off_display, digit
    );
endinterface

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Purpose : shares one 4-digit 7-segment driver between two clients.
//           Round-robin arbitration with a minimum ownership time counted in
//           tick_banner strobes, and an optional blank guard frame between
//           owners. Scans the owner's 16-bit word onto value/off_display in
//           step with tick_display.
//
// Ports   : clk   system clock
//           rst   asynchronous, active-low reset
//           bus   display_arbiter_if.slave (strobes, client inputs, outputs)
//
// Params  : HOLD_TICKS  minimum tick_banner count before preemption (0..255)
//
// Config  : DISPLAY_ARB_GUARD_EN defined   -> owners are separated by a
//                                             4-strobe blank GUARD frame.
//           DISPLAY_ARB_GUARD_EN undefined -> OWN returns straight to IDLE,
//                                             leaving a single gnt=0 cycle.
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    display_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);

    state_t      r_state;
    logic        r_owner;       // 0 = client 0, 1 = client 1 (valid in OWN)
    logic        r_last_owner;  // owner most recently released
    logic [7:0]  r_hold;
    logic [1:0]  r_guard_cnt;
    logic [1:0]  r_gnt;
    logic [3:0]  r_value;
    logic        r_off;
    logic [1:0]  r_digit;

    logic [1:0]  w_next_digit;
    logic [15:0] w_own_data;
    logic [3:0]  w_own_blank;
    logic        w_own_req;
    logic        w_other_req;
    logic        w_pick;
    logic        w_leave;

    always_comb begin
        w_next_digit = r_digit + 2'd1;
        w_own_data   = r_owner ? bus.data1  : bus.data0;
        w_own_blank  = r_owner ? bus.blank1 : bus.blank0;
        w_own_req    = r_owner ? bus.req[1] : bus.req[0];
        w_other_req  = r_owner ? bus.req[0] : bus.req[1];
        // On a tie the client that did not own last wins; otherwise the lone
        // requester (req[1] set means client 1, else client 0).
        w_pick       = (bus.req == 2'b11) ? ~r_last_owner : bus.req[1];
        // Preemption looks at the hold count before this cycle's decrement,
        // so a count reaching 0 only allows preemption on the next edge.
        w_leave      = (r_state == S_OWN) &&
                       (!w_own_req || ((r_hold == 8'd0) && w_other_req));
    end

    // NOTE: every register, including the FSM and the registered outputs,
    // sits in this one block with non-blocking assignments; a later <= to the
    // same register in the same edge overrides an earlier one, which is how
    // the guard frame forces off_display over the scan update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_hold       <= 8'd0;
            r_guard_cnt  <= 2'd0;
            r_gnt        <= 2'b00;
            r_value      <= 4'd0;
            r_off        <= 1'b1;
            r_digit      <= 2'd0;
        end else begin
            // Scan runs in every state; only the owner's word reaches value.
            if (bus.tick_display) begin
                r_digit <= w_next_digit;
                if (r_state == S_OWN) begin
                    r_value <= w_own_data[4*w_next_digit +: 4];
                    r_off   <= w_own_blank[w_next_digit];
                end else begin
                    r_off   <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.req != 2'b00) begin
                        r_state <= S_OWN;
                        r_owner <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_hold  <= HOLD_INIT;
                    end
                end

                S_OWN: begin
                    if (w_leave) begin
                        r_last_owner <= r_owner;
                        r_gnt        <= 2'b00;
`ifdef DISPLAY_ARB_GUARD_EN
                        r_state      <= S_GUARD;
                        r_guard_cnt  <= 2'd0;
                        r_off        <= 1'b1;
`else
                        r_state      <= S_IDLE;
`endif
                    end else if (bus.tick_banner && (r_hold != 8'd0)) begin
                        r_hold <= r_hold - 8'd1;
                    end
                end

                S_GUARD: begin
                    // One blank frame: leave on the edge sampling the 4th strobe.
                    if (bus.tick_display) begin
                        if (r_guard_cnt == 2'd3) begin
                            r_state <= S_IDLE;
                        end
                        r_guard_cnt <= r_guard_cnt + 2'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.value       = r_value;
    assign bus.off_display = r_off;
    assign bus.digit       = r_digit;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Purpose : self-checking bench for display_arbiter (HOLD_TICKS = 2).
//           Scan results are predicted when each tick_display is driven,
//           queued, and compared after the DUT edge. Grant and reset values
//           are compared against constants. Works with and without
//           DISPLAY_ARB_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    display_arbiter_if bus ();

    display_arbiter #(.HOLD_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0] digit;
        logic [3:0] value;
        logic       off;
    } scan_t;

    scan_t      sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    // Reference model of the display side.
    int         m_own   = -1;   // -1 none, else owning client index
    bit         m_guard = 1'b0;
    int         m_gcnt  = 0;
    logic [1:0] m_digit = 2'd0;
    logic [3:0] m_value = 4'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one tick_display strobe, predict the scan update, compare.
    task automatic strobe(input string tag);
        scan_t       e;
        scan_t       got;
        logic [1:0]  nd;
        logic [15:0] d;
        logic [3:0]  b;
        nd      = m_digit + 2'd1;
        e.digit = nd;
        e.value = m_value;
        e.off   = 1'b1;
        if (m_own >= 0 && !m_guard) begin
            d       = (m_own == 1) ? bus.data1  : bus.data0;
            b       = (m_own == 1) ? bus.blank1 : bus.blank0;
            e.value = d[4*nd +: 4];
            e.off   = b[nd];
        end
        m_digit = nd;
        m_value = e.value;
        sb_q.push_back(e);
        bus.tick_display = 1'b1;
        step();
        bus.tick_display = 1'b0;
        if (m_guard) begin
            m_gcnt++;
            if (m_gcnt == 4) m_guard = 1'b0;
        end
        got = sb_q.pop_front();
        check({tag, "_digit"}, 32'(bus.digit),       32'(got.digit));
        check({tag, "_value"}, 32'(bus.value),       32'(got.value));
        check({tag, "_off"},   32'(bus.off_display), 32'(got.off));
    endtask

    task automatic banner(input string tag, input logic [1:0] exp_gnt);
        bus.tick_banner = 1'b1;
        step();
        bus.tick_banner = 1'b0;
        check(tag, 32'(bus.gnt), 32'(exp_gnt));
    endtask

    // The leave condition is already set up on the inputs: one edge to drop
    // the grant, an optional blank frame, then one edge to grant next_own.
    task automatic handover(input string tag, input int next_own);
        step();
        check({tag, "_drop"}, 32'(bus.gnt), 32'd0);
        m_own = -1;
`ifdef DISPLAY_ARB_GUARD_EN
        m_guard = 1'b1;
        m_gcnt  = 0;
        for (int i = 0; i < 4; i++) begin
            strobe({tag, "_guard"});
            check({tag, "_guard_gnt"}, 32'(bus.gnt), 32'd0);
        end
`endif
        step();
        check({tag, "_grant"}, 32'(bus.gnt), (next_own == 1) ? 32'd2 : 32'd1);
        m_own = next_own;
    endtask

    initial begin
        bus.tick_display = 1'b0;
        bus.tick_banner  = 1'b0;
        bus.req          = 2'b01;
        bus.data0        = 16'h3210;
        bus.data1        = 16'hBA98;
        bus.blank0       = 4'b0000;
        bus.blank1       = 4'b0000;

        // Reset state.
        repeat (3) step();
        check("rst_gnt",   32'(bus.gnt),         32'd0);
        check("rst_off",   32'(bus.off_display), 32'd1);
        check("rst_digit", 32'(bus.digit),       32'd0);
        check("rst_value", 32'(bus.value),       32'd0);

        // Release reset: client 0 granted one edge later.
        rst = 1'b1;
        step();
        check("first_gnt", 32'(bus.gnt), 32'd1);
        m_own = 0;
        for (int i = 0; i < 4; i++) strobe("scan0");

        // Per-digit blank mask.
        bus.blank0 = 4'b1010;
        for (int i = 0; i < 4; i++) strobe("blank0");
        bus.blank0 = 4'b0000;

        // Early release with hold count still non-zero; client 1 takes over.
        bus.req = 2'b10;
        handover("early", 1);
        for (int i = 0; i < 2; i++) strobe("scan1");

        // Tie: preemption after HOLD_TICKS banners, evaluated pre-decrement.
        bus.req = 2'b11;
        banner("tie1_hold_a", 2'b10);
        banner("tie1_hold_b", 2'b10);
        handover("preempt_to0", 0);
        for (int i = 0; i < 2; i++) strobe("scan_tie0");
        banner("tie0_hold_a", 2'b01);
        banner("tie0_hold_b", 2'b01);
        handover("preempt_to1", 1);
        strobe("scan_tie1");

        // Drop coinciding with tick_banner while hold is non-zero.
        bus.req         = 2'b00;
        bus.tick_banner = 1'b1;
        step();
        bus.tick_banner = 1'b0;
        check("drop_banner_gnt", 32'(bus.gnt), 32'd0);
        m_own = -1;
`ifdef DISPLAY_ARB_GUARD_EN
        m_guard = 1'b1;
        m_gcnt  = 0;
`endif
        for (int i = 0; i < 2; i++) strobe("drop_scan");

        // Asynchronous reset between clock edges.
        rst = 1'b0;
        #1;
        check("arst_off",   32'(bus.off_display), 32'd1);
        check("arst_digit", 32'(bus.digit),       32'd0);
        check("arst_gnt",   32'(bus.gnt),         32'd0);
        check("arst_value", 32'(bus.value),       32'd0);
        m_digit = 2'd0;
        m_value = 4'd0;
        m_guard = 1'b0;
        bus.req = 2'b10;
        step();
        rst = 1'b1;
        step();
        check("post_rst_gnt", 32'(bus.gnt), 32'd2);
        m_own = 1;

        // Lone owner keeps the display after the hold time expires.
        banner("lone_a", 2'b10);
        banner("lone_b", 2'b10);
        banner("lone_c", 2'b10);
        strobe("lone_scan");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
